data_packer: RTL and testbench
==============================

# data_packer

Assembles a stream of narrow words from a source BRAM into wide words and writes them to a destination BRAM, first narrow word in the MSB lane. It sits next to `data_parser` and is its inverse. It packs byte-oriented intermediate buffers (seeds, commitments, hash inputs) back into the wide word memories that the signing datapath uses. A final partial word is zero-padded in its low lanes.

## Interface
- NARROW_WIDTH, 8, width of a source BRAM word.
- WIDE_WIDTH, 32, width of a destination BRAM word; must be an integer multiple R = WIDE_WIDTH/NARROW_WIDTH, with R ≥ 2.
- SOURCE_BRAM_DEPTH, 15, number of narrow words S to read, addresses 0..S-1.
- DESTINATION_BRAM_DEPTH, 4, destination depth; must be ≥ ceil(S/R).
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start pulse; sampled only in S_IDLE.
- o_done  out  1  one-cycle pulse after the last write.
- i_narrow_in  in  NARROW_WIDTH  source BRAM read data, 1-cycle read latency.
- o_narrow_in_addr  out  `CLOG2(SOURCE_BRAM_DEPTH)  source read address.
- o_narrow_in_rd  out  1  source read enable.
- o_wide_out  out  WIDE_WIDTH  destination write data.
- o_wide_out_addr  out  `CLOG2(DESTINATION_BRAM_DEPTH)  destination write address.
- o_wide_out_en  out  1  destination write enable.

## Operation
- **States**
  - S_IDLE: on i_start, go to S_READ. Read address, lane counter, write address and shift register are all cleared.
  - S_READ: o_narrow_in_rd=1 and the address increments each cycle from 0 to S-1. After issuing S-1, go to S_FLUSH.
  - S_FLUSH: waits for the last read data. If P = (R - S mod R) mod R > 0, shift in P zero lanes, one per cycle, then go to S_DONE once the final write is issued.
  - S_DONE: o_done=1 for one cycle, then go to S_IDLE.
- **Capture**
  - A registered copy of o_narrow_in_rd marks i_narrow_in as valid.
  - On each valid cycle: shift register <= {sreg[WIDE_WIDTH-NARROW_WIDTH-1:0], i_narrow_in}; the lane counter increments modulo R.
  - Padding cycles shift in zero in place of i_narrow_in.
- **Write**
  - When lane R-1 is captured, the next cycle asserts o_wide_out_en=1 with o_wide_out=sreg and o_wide_out_addr=w.
  - w increments after each write and runs 0..ceil(S/R)-1. It is never written beyond that range.
- **Start handling**: i_start is ignored in S_READ, S_FLUSH and S_DONE. No queuing.
- **Reset**: i_rst at any time, including mid-run, returns to S_IDLE. All counters and the shift register are cleared; no further reads or writes occur.

## Timing
- **Reset values**: o_done=0, o_narrow_in_rd=0, o_narrow_in_addr=0, o_wide_out_en=0, o_wide_out=0, o_wide_out_addr=0.
- **Cycle numbering**: cycle 0 is the cycle in which i_start is sampled in S_IDLE.
- **Reads**: address k is presented in cycle k+1, and its data is valid on i_narrow_in in cycle k+2.
- **Writes**: word w is written in cycle R·w+R+2 (for R=4, cycle 4w+6). The final write lands in cycle S+2+P.
- **Completion**: o_done is high in cycle S+3+P. The earliest accepted restart is i_start in the cycle after o_done.
- **Address counter**: o_narrow_in_addr holds S-1 after the last read; it is not wrapped.
- **Duration**: total run is S+4+P cycles, start to return to idle.

## Test plan
- **Default run** (S=15, R=4), source[i]=0xA0+i:
  - Writes 0xA0A1A2A3@0 (cycle 6), 0xA4A5A6A7@1 (cycle 10), 0xA8A9AAAB@2 (cycle 14) and 0xACADAE00@3 (cycle 18).
  - o_done in cycle 19, exactly 4 writes.
- **Exact multiple** (S=16), source[i]=i:
  - Last word is 0x0C0D0E0F@3, written in cycle 18.
  - o_done in cycle 19, no padding cycle.
- **i_start pulsed in cycles 3 and 10**: no effect; output identical to the default run.
- **Reset mid-run**:
  - i_rst in cycle 8: all outputs 0 next cycle; no write after cycle 8.
  - Restart: fresh run reproduces the default-run results.
- **Back-to-back runs**: i_start in the cycle after o_done. The second run's writes begin 6 cycles later with identical data.
- **Round trip**:
  - Default run with random source data, then `data_parser` reads the destination BRAM back.
  - The parser reproduces source[0..14] exactly.

Source files
------------

// File: rtl/data_packer_if.sv
// data_packer bus bundle
// source read port, destination write port and start/done
interface data_packer_if #(
  parameter int NARROW_WIDTH           = 8,
  parameter int WIDE_WIDTH             = 32,
  parameter int SOURCE_BRAM_DEPTH      = 15,
  parameter int DESTINATION_BRAM_DEPTH = 4
);
  localparam int SAW =
    (SOURCE_BRAM_DEPTH > 1) ? $clog2(SOURCE_BRAM_DEPTH) : 1;
  localparam int DAW =
    (DESTINATION_BRAM_DEPTH > 1) ? $clog2(DESTINATION_BRAM_DEPTH) : 1;

  logic                    i_start;
  logic                    o_done;
  logic [NARROW_WIDTH-1:0] i_narrow_in;
  logic [SAW-1:0]          o_narrow_in_addr;
  logic                    o_narrow_in_rd;
  logic [WIDE_WIDTH-1:0]   o_wide_out;
  logic [DAW-1:0]          o_wide_out_addr;
  logic                    o_wide_out_en;

  modport master (
    input  i_start,
    input  i_narrow_in,
    output o_done,
    output o_narrow_in_addr,
    output o_narrow_in_rd,
    output o_wide_out,
    output o_wide_out_addr,
    output o_wide_out_en
  );

  modport slave (
    output i_start,
    output i_narrow_in,
    input  o_done,
    input  o_narrow_in_addr,
    input  o_narrow_in_rd,
    input  o_wide_out,
    input  o_wide_out_addr,
    input  o_wide_out_en
  );
endinterface

// File: rtl/data_packer.sv
// data_packer: narrow BRAM stream -> wide BRAM words
// first narrow word lands in the MSB lane, tail zero-padded
module data_packer #(
  parameter int NARROW_WIDTH           = 8,
  parameter int WIDE_WIDTH             = 32,
  parameter int SOURCE_BRAM_DEPTH      = 15,
  parameter int DESTINATION_BRAM_DEPTH = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  data_packer_if.master bus
);
  localparam int R  = WIDE_WIDTH / NARROW_WIDTH;
  localparam int LW = $clog2(R);
  localparam int SAW =
    (SOURCE_BRAM_DEPTH > 1) ? $clog2(SOURCE_BRAM_DEPTH) : 1;
  localparam int DAW =
    (DESTINATION_BRAM_DEPTH > 1) ? $clog2(DESTINATION_BRAM_DEPTH) : 1;
  localparam logic [SAW-1:0] ADDR_LAST = SAW'(SOURCE_BRAM_DEPTH - 1);
  localparam logic [LW-1:0]  LANE_LAST = LW'(R - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [SAW-1:0]          r_addr;
  logic [LW-1:0]           r_lane;
  logic [DAW-1:0]          r_waddr;
  logic [WIDE_WIDTH-1:0]   r_sreg;
  logic                    r_rd_q;
  logic                    r_wen;
  logic                    w_rd;
  logic                    w_pad;
  logic                    w_shift;
  logic                    w_lane_last;
  logic                    w_last_addr;
  logic [NARROW_WIDTH-1:0] w_din;

  assign w_last_addr = (r_addr == ADDR_LAST);
  assign w_lane_last = (r_lane == LANE_LAST);
  assign w_shift     = r_rd_q | w_pad;
  assign w_din       = r_rd_q ? bus.i_narrow_in : '0;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state, read strobe and zero-pad request
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_pad  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_next = S_READ;
      end
      S_READ: begin
        w_rd = 1'b1;
        if (w_last_addr) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        // pad only once the last real lane is in
        w_pad = !r_rd_q && (r_lane != '0);
        if (!r_rd_q && (r_lane == '0) && r_wen)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // read data valid flag and write strobe pipeline
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_q <= 1'b0;
      r_wen  <= 1'b0;
    end else begin
      r_rd_q <= w_rd;
      r_wen  <= w_shift && w_lane_last;
    end
  end

  // source read address: cleared in idle, holds last
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= '0;
    end else if (r_state == S_IDLE) begin
      r_addr <= '0;
    end else if (w_rd && !w_last_addr) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // lane shift register and lane counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sreg <= '0;
      r_lane <= '0;
    end else if (r_state == S_IDLE) begin
      r_sreg <= '0;
      r_lane <= '0;
    end else if (w_shift) begin
      r_sreg <= {r_sreg[WIDE_WIDTH-NARROW_WIDTH-1:0], w_din};
      r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
    end
  end

  // destination address advances after each write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_waddr <= '0;
    end else if (r_state == S_IDLE) begin
      r_waddr <= '0;
    end else if (r_wen) begin
      r_waddr <= r_waddr + 1'b1;
    end
  end

  assign bus.o_done           = (r_state == S_DONE);
  assign bus.o_narrow_in_rd   = w_rd;
  assign bus.o_narrow_in_addr = r_addr;
  assign bus.o_wide_out       = r_sreg;
  assign bus.o_wide_out_addr  = r_waddr;
  assign bus.o_wide_out_en    = r_wen;

endmodule

// File: tb/tb_data_packer.sv
// tb_data_packer: directed checks of data_packer
// dut a: S=15 (padded tail), dut b: S=16 (exact multiple)
module tb_data_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  data_packer_if #(8, 32, 15, 4) bus_a ();
  data_packer_if #(8, 32, 16, 4) bus_b ();

  data_packer #(
    .NARROW_WIDTH(8), .WIDE_WIDTH(32),
    .SOURCE_BRAM_DEPTH(15), .DESTINATION_BRAM_DEPTH(4)
  ) u_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));

  data_packer #(
    .NARROW_WIDTH(8), .WIDE_WIDTH(32),
    .SOURCE_BRAM_DEPTH(16), .DESTINATION_BRAM_DEPTH(4)
  ) u_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  src_a [16];
  logic [7:0]  src_b [16];
  logic [31:0] dst_a [4];

  // source BRAMs, one cycle read latency
  always @(posedge clk) begin
    if (bus_a.o_narrow_in_rd)
      bus_a.i_narrow_in <= src_a[bus_a.o_narrow_in_addr];
    if (bus_b.o_narrow_in_rd)
      bus_b.i_narrow_in <= src_b[bus_b.o_narrow_in_addr];
  end

  int          t0 [2];
  int          wn [2];
  int          dn [2];
  int          wr_cyc [2][16];
  int          wr_adr [2][16];
  logic [31:0] wr_dat [2][16];
  int          dn_cyc [2][4];
  logic [31:0] exp_w [2][4];

  // write / done logger, relative to the run's start cycle
  always @(negedge clk) begin
    if (bus_a.o_wide_out_en) begin
      dst_a[bus_a.o_wide_out_addr] = bus_a.o_wide_out;
      if (wn[0] < 16) begin
        wr_cyc[0][wn[0]] = cyc - t0[0];
        wr_adr[0][wn[0]] = int'(bus_a.o_wide_out_addr);
        wr_dat[0][wn[0]] = bus_a.o_wide_out;
      end
      wn[0]++;
    end
    if (bus_b.o_wide_out_en) begin
      if (wn[1] < 16) begin
        wr_cyc[1][wn[1]] = cyc - t0[1];
        wr_adr[1][wn[1]] = int'(bus_b.o_wide_out_addr);
        wr_dat[1][wn[1]] = bus_b.o_wide_out;
      end
      wn[1]++;
    end
    if (bus_a.o_done) begin
      if (dn[0] < 4) dn_cyc[0][dn[0]] = cyc - t0[0];
      dn[0]++;
    end
    if (bus_b.o_done) begin
      if (dn[1] < 4) dn_cyc[1][dn[1]] = cyc - t0[1];
      dn[1]++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] done_addr;

  // start in relative cycle 0, optional extra start pulses
  task automatic run(input int d, input int p1,
                     input int p2, input int len);
    wn[d] = 0;
    dn[d] = 0;
    t0[d] = cyc;
    done_addr = 32'hFFFF_FFFF;
    for (int n = 0; n < len; n++) begin
      if (d == 0) bus_a.i_start = (n == 0 || n == p1 || n == p2);
      else        bus_b.i_start = (n == 0 || n == p1 || n == p2);
      @(negedge clk);
      if (d == 0 && bus_a.o_done)
        done_addr = 32'(bus_a.o_narrow_in_addr);
    end
    bus_a.i_start = 1'b0;
    bus_b.i_start = 1'b0;
  endtask

  // four writes of one run starting at log index base
  task automatic check_run(input string nm, input int d,
                           input int base, input int off);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s_addr%0d", nm, j),
          32'(wr_adr[d][base+j]), 32'(j));
      chk($sformatf("%s_data%0d", nm, j),
          wr_dat[d][base+j], exp_w[d][j]);
      chk($sformatf("%s_cyc%0d", nm, j),
          32'(wr_cyc[d][base+j]), 32'(6 + 4*j + off));
    end
    chk($sformatf("%s_done_cyc", nm),
        32'(dn_cyc[d][base/4]), 32'(19 + off));
  endtask

  initial begin
    bus_a.i_start = 1'b0;
    bus_b.i_start = 1'b0;
    wn[0] = 0; wn[1] = 0; dn[0] = 0; dn[1] = 0;
    t0[0] = 0; t0[1] = 0;
    for (int i = 0; i < 16; i++) begin
      src_a[i] = 8'(8'hA0 + i);
      src_b[i] = 8'(i);
    end
    exp_w[0][0] = 32'hA0A1A2A3;
    exp_w[0][1] = 32'hA4A5A6A7;
    exp_w[0][2] = 32'hA8A9AAAB;
    exp_w[0][3] = 32'hACADAE00;
    exp_w[1][0] = 32'h00010203;
    exp_w[1][1] = 32'h04050607;
    exp_w[1][2] = 32'h08090A0B;
    exp_w[1][3] = 32'h0C0D0E0F;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(bus_a.o_done), 32'd0);
    chk("rst_rd", 32'(bus_a.o_narrow_in_rd), 32'd0);
    chk("rst_raddr", 32'(bus_a.o_narrow_in_addr), 32'd0);
    chk("rst_wen", 32'(bus_a.o_wide_out_en), 32'd0);
    chk("rst_wdata", bus_a.o_wide_out, 32'd0);
    chk("rst_waddr", 32'(bus_a.o_wide_out_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // default run, padded tail
    run(0, -1, -1, 30);
    chk("def_wcnt", 32'(wn[0]), 32'd4);
    chk("def_dcnt", 32'(dn[0]), 32'd1);
    chk("def_raddr_hold", done_addr, 32'd14);
    check_run("def", 0, 0, 0);

    // exact multiple, no padding
    run(1, -1, -1, 30);
    chk("exact_wcnt", 32'(wn[1]), 32'd4);
    chk("exact_dcnt", 32'(dn[1]), 32'd1);
    check_run("exact", 1, 0, 0);

    // stray start pulses mid-run are ignored
    run(0, 3, 10, 30);
    chk("ign_wcnt", 32'(wn[0]), 32'd4);
    chk("ign_dcnt", 32'(dn[0]), 32'd1);
    check_run("ign", 0, 0, 0);

    // reset asserted in cycle 8
    wn[0] = 0;
    dn[0] = 0;
    t0[0] = cyc;
    for (int n = 0; n < 8; n++) begin
      bus_a.i_start = (n == 0);
      @(negedge clk);
    end
    bus_a.i_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_done", 32'(bus_a.o_done), 32'd0);
    chk("mid_rd", 32'(bus_a.o_narrow_in_rd), 32'd0);
    chk("mid_raddr", 32'(bus_a.o_narrow_in_addr), 32'd0);
    chk("mid_wen", 32'(bus_a.o_wide_out_en), 32'd0);
    chk("mid_wdata", bus_a.o_wide_out, 32'd0);
    chk("mid_waddr", 32'(bus_a.o_wide_out_addr), 32'd0);
    repeat (20) @(negedge clk);
    chk("mid_wcnt", 32'(wn[0]), 32'd1);
    chk("mid_wcyc", 32'(wr_cyc[0][0]), 32'd6);
    chk("mid_dcnt", 32'(dn[0]), 32'd0);

    // restart after reset
    run(0, -1, -1, 30);
    chk("rerun_wcnt", 32'(wn[0]), 32'd4);
    check_run("rerun", 0, 0, 0);

    // back-to-back: second start in the cycle after done
    run(0, 20, -1, 50);
    chk("b2b_wcnt", 32'(wn[0]), 32'd8);
    chk("b2b_dcnt", 32'(dn[0]), 32'd2);
    check_run("b2b_first", 0, 0, 0);
    check_run("b2b_second", 0, 4, 20);

    // round trip with random bytes, unpacked MSB lane first
    for (int i = 0; i < 15; i++) src_a[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) dst_a[i] = 32'hDEAD_BEEF;
    run(0, -1, -1, 30);
    for (int i = 0; i < 15; i++) begin
      logic [31:0] w;
      w = dst_a[i/4];
      chk($sformatf("rt_byte%0d", i),
          32'(w[31-8*(i%4) -: 8]), 32'(src_a[i]));
    end
    begin
      logic [31:0] w;
      w = dst_a[3];
      chk("rt_pad", 32'(w[7:0]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
